// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer handshake bundle: receiver-side byte/ready inputs, the consumer
// valid/pop handshake, and the occupancy/overrun status.
// The FIFO is the slave. The consumer/receiver side is the master.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_en;
  logic [AW:0] count;
  logic        full;
  logic        overrun;
  logic        clr_overrun;
  logic [7:0]  ovr_count;

  modport slave (
    input  rx_data, rx_ready, rd_en, clr_overrun,
    output rd_data, rd_valid, count, full, overrun, ovr_count
  );

  modport master (
    output rx_data, rx_ready, rd_en, clr_overrun,
    input  rd_data, rd_valid, count, full, overrun, ovr_count
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer.
// - A rising edge of the receiver's level-type ready flag pushes one byte into a
//   show-ahead FIFO.
// - The consumer pops through rd_valid/rd_en.
// - Bytes arriving while the FIFO is full are dropped, and a sticky overrun flag
//   is raised.
// Optional: define UART_RX_FIFO_OVR_CNT_EN to add a saturating 8-bit count of
// dropped bytes. Without it, ovr_count is tied to zero.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          rx_ready_q;
  logic          overrun;

  logic push;
  logic pop_ok;
  logic push_ok;
  logic drop;
  logic is_full;
  logic is_empty;

  assign is_full  = (count == FULL_CNT);
  assign is_empty = (count == '0);

  // A ready level held across reset release must not count as a new frame,
  // so rx_ready_q resets high.
  assign push    = bus.rx_ready & ~rx_ready_q;
  assign pop_ok  = bus.rd_en & ~is_empty;
  // When full, a same-cycle pop frees the slot, so the push is still accepted.
  assign push_ok = push & (~is_full | pop_ok);
  assign drop    = push & is_full & ~pop_ok;

  assign bus.count    = count;
  assign bus.full     = is_full;
  assign bus.rd_valid = ~is_empty;
  assign bus.rd_data  = is_empty ? 8'h00 : mem[rd_ptr];
  assign bus.overrun  = overrun;

  // Edge detector for the receiver frame-done flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_ready_q <= 1'b1;
    else      rx_ready_q <= bus.rx_ready;
  end

  // Byte storage. This array is not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.rx_data;
  end

  // Pointers and occupancy. The pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun flag. A new drop takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 overrun <= 1'b0;
    else if (drop)            overrun <= 1'b1;
    else if (bus.clr_overrun) overrun <= 1'b0;
  end

`ifdef UART_RX_FIFO_OVR_CNT_EN
  logic [7:0] ovr_count;
  assign bus.ovr_count = ovr_count;

  // Saturating dropped-byte counter. A drop in the clear cycle restarts it at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_count <= 8'h00;
    end else if (drop) begin
      if (bus.clr_overrun)         ovr_count <= 8'h01;
      else if (ovr_count != 8'hFF) ovr_count <= ovr_count + 8'h01;
    end else if (bus.clr_overrun) begin
      ovr_count <= 8'h00;
    end
  end
`else
  assign bus.ovr_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo.
// - A queue-based model is advanced once per clock and compared against every
//   output on each falling edge.
// - Directed scenarios add literal expectations.
// - A randomized phase follows, with occasional asynchronous resets.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  // Behavioural model state.
  logic [7:0] q[$];
  bit         m_rdy_q   = 1'b1;
  bit         m_ovr     = 1'b0;
  int         m_ovr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_ovr_cnt();
`ifdef UART_RX_FIFO_OVR_CNT_EN
    return m_ovr_cnt;
`else
    return 0;
`endif
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("rd_valid",  {31'd0, bus.rd_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
      chk("rd_data",   {24'd0, bus.rd_data},  (q.size() > 0) ? {24'd0, q[0]} : 32'd0);
      chk("count",     {{(31-AW){1'b0}}, bus.count}, q.size());
      chk("full",      {31'd0, bus.full},     (q.size() == DEPTH) ? 32'd1 : 32'd0);
      chk("overrun",   {31'd0, bus.overrun},  {31'd0, m_ovr});
      chk("ovr_count", {24'd0, bus.ovr_count}, exp_ovr_cnt());
    end
  end

  task automatic model_reset();
    q.delete();
    m_rdy_q   = 1'b1;
    m_ovr     = 1'b0;
    m_ovr_cnt = 0;
  endtask

  // Drive one cycle of inputs, let the DUT sample them, then advance the model.
  task automatic step(input bit rdy, input logic [7:0] d, input bit re, input bit clr);
    bit push, pop, drop;
    bus.rx_ready    = rdy;
    bus.rx_data     = d;
    bus.rd_en       = re;
    bus.clr_overrun = clr;
    @(posedge clk);
    #1;
    push = rdy && !m_rdy_q;
    pop  = re && (q.size() > 0);
    drop = push && (q.size() == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (push && !drop) q.push_back(d);
    if (drop) begin
      m_ovr     = 1'b1;
      m_ovr_cnt = clr ? 1 : ((m_ovr_cnt == 255) ? 255 : m_ovr_cnt + 1);
    end else if (clr) begin
      m_ovr     = 1'b0;
      m_ovr_cnt = 0;
    end
    m_rdy_q = rdy;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Assert reset asynchronously between edges, then release it 1 ns after an edge.
  task automatic do_reset(input int cycles);
    #2 rst = 1'b0;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    idle();
  endtask

  bit         r_rdy;
  logic [7:0] r_dat;

  initial begin
    bus.rx_ready    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rd_en       = 1'b0;
    bus.clr_overrun = 1'b0;
    model_reset();
    @(posedge clk);
    #1 checking = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state, then three long frames.
    chk("rst_count", {{(31-AW){1'b0}}, bus.count}, 0);
    chk("rst_rd_data", {24'd0, bus.rd_data}, 0);
    repeat (3) idle();
    for (int b = 0; b < 3; b++) begin
      repeat (50) step(1'b1, 8'h41 + b[7:0], 1'b0, 1'b0);
      repeat (5) idle();
    end
    chk("t1_count", {{(31-AW){1'b0}}, bus.count}, 3);
    chk("t1_head", {24'd0, bus.rd_data}, 32'h41);
    for (int b = 0; b < 3; b++) begin
      chk("t1_pop_data", {24'd0, bus.rd_data}, 32'h41 + b);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t1_empty_valid", {31'd0, bus.rd_valid}, 0);
    chk("t1_empty_data", {24'd0, bus.rd_data}, 0);

    // rx_ready held across reset release must not push.
    bus.rx_ready = 1'b1;
    bus.rx_data  = 8'h33;
    do_reset(3);
    repeat (5) step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("t2_no_push", {{(31-AW){1'b0}}, bus.count}, 0);
    idle();
    repeat (3) step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("t2_count", {{(31-AW){1'b0}}, bus.count}, 1);
    chk("t2_data", {24'd0, bus.rd_data}, 32'h5A);

    // DEPTH+2 pushes with no pops: two bytes dropped.
    do_reset(2);
    idle();
    for (int i = 0; i < DEPTH + 2; i++) push_byte(i[7:0]);
    chk("t3_full", {31'd0, bus.full}, 1);
    chk("t3_overrun", {31'd0, bus.overrun}, 1);
`ifdef UART_RX_FIFO_OVR_CNT_EN
    chk("t3_ovr_count", {24'd0, bus.ovr_count}, 2);
`else
    chk("t3_ovr_count", {24'd0, bus.ovr_count}, 0);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_drain", {24'd0, bus.rd_data}, i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t3_drained", {31'd0, bus.rd_valid}, 0);

    // Full FIFO: a push and a pop in the same cycle.
    do_reset(2);
    idle();
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + i[7:0]);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("t4_count", {{(31-AW){1'b0}}, bus.count}, DEPTH);
    chk("t4_no_ovr", {31'd0, bus.overrun}, 0);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      chk("t4_drain", {24'd0, bus.rd_data}, (i < DEPTH - 1) ? 32'h11 + i : 32'h77);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Pop on empty with a simultaneous push, then a clear in the same cycle as a drop.
    do_reset(2);
    idle();
    step(1'b1, 8'h99, 1'b1, 1'b0);
    chk("t5_count", {{(31-AW){1'b0}}, bus.count}, 1);
    chk("t5_data", {24'd0, bus.rd_data}, 32'h99);
    idle();
    for (int i = 0; i < DEPTH + 1; i++) push_byte(8'hA0 + i[7:0]);
    step(1'b1, 8'hAB, 1'b0, 1'b1);
    idle();
    chk("t5_ovr", {31'd0, bus.overrun}, 1);
`ifdef UART_RX_FIFO_OVR_CNT_EN
    chk("t5_ovr_count", {24'd0, bus.ovr_count}, 1);
`else
    chk("t5_ovr_count", {24'd0, bus.ovr_count}, 0);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t5_cleared", {31'd0, bus.overrun}, 0);

    // Push and pop at occupancy 1 across several pointer wraps.
    do_reset(2);
    idle();
    push_byte(8'hC0);
    for (int i = 0; i < 40; i++) begin
      chk("t6_order", {24'd0, bus.rd_data}, 32'hC0 + i);
      step(1'b1, 8'hC1 + i[7:0], 1'b1, 1'b0);
      chk("t6_count_le2", (bus.count <= 2) ? 32'd1 : 32'd0, 1);
      idle();
    end

    // Randomized traffic, checked by the per-cycle model compare.
    do_reset(2);
    idle();
    r_rdy = 1'b0;
    r_dat = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(999) < 3) begin
        do_reset($urandom_range(3, 1));
        r_rdy = 1'b0;
        idle();
      end else begin
        if ($urandom_range(99) < 35) begin
          r_rdy = ~r_rdy;
          if (r_rdy) r_dat = 8'($urandom);
        end
        if (!r_rdy) r_dat = 8'($urandom);
        step(r_rdy, r_dat, ($urandom_range(99) < ((n / 500) % 2 == 0 ? 15 : 60)),
             ($urandom_range(99) < 4));
      end
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
